// File: rtl/ps_window_mc.sv
// ps_window_mc: multi-channel block signal-power estimator (per-channel sum of squares over 2^WIN_LOG2 samples).
// Optional macro PS_MEAN_EN: emit the block mean (sum >> WIN_LOG2) instead of the raw sum.
module ps_window_mc #(
   parameter int DATA_WIDTH   = 16,
   parameter int CH_NUM       = 4,
   parameter int WIN_LOG2     = 8,
   parameter int OUTPUT_WIDTH = 40,
   localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic signed [DATA_WIDTH-1:0]   din,
   input  logic        [CH_W-1:0]         ch,
   output logic signed [OUTPUT_WIDTH-1:0] dout,
   output logic        [CH_W-1:0]         dout_ch,
   output logic                           data_valid,
   output logic                           sat
);

   localparam int SQ_W  = 2 * DATA_WIDTH;
   localparam int ACC_W = SQ_W + WIN_LOG2;
   localparam int CMP_W = (ACC_W > OUTPUT_WIDTH) ? ACC_W : OUTPUT_WIDTH;
   localparam logic [CH_W:0]         CH_LIM   = (CH_W + 1)'(CH_NUM);
   localparam logic [WIN_LOG2-1:0]   CNT_LAST = '1;
   localparam logic [WIN_LOG2-1:0]   CNT_ONE  = WIN_LOG2'(1);
   localparam logic [CMP_W-1:0]      OUT_MAX  = CMP_W'({(OUTPUT_WIDTH - 1){1'b1}});

   function automatic logic [ACC_W-1:0] scale(input logic [ACC_W-1:0] x);
`ifdef PS_MEAN_EN
      return x >> WIN_LOG2;
`else
      return x;
`endif
   endfunction

   // Returns {saturated flag, clamped value}.
   function automatic logic [OUTPUT_WIDTH:0] saturate(input logic [ACC_W-1:0] x);
      logic [CMP_W-1:0] xw;
      xw = CMP_W'(x);
      if (xw > OUT_MAX) return {1'b1, OUT_MAX[OUTPUT_WIDTH-1:0]};
      return {1'b0, xw[OUTPUT_WIDTH-1:0]};
   endfunction

   logic signed [SQ_W-1:0]         din_x;
   logic signed [SQ_W-1:0]         prod;

   logic                           vld_p1_d, vld_p1_q;
   logic        [SQ_W-1:0]         sq_p1_d, sq_p1_q;
   logic        [CH_W-1:0]         ch_p1_d, ch_p1_q;

   logic        [ACC_W-1:0]        acc_d [CH_NUM];
   logic        [ACC_W-1:0]        acc_q [CH_NUM];
   logic        [WIN_LOG2-1:0]     cnt_d [CH_NUM];
   logic        [WIN_LOG2-1:0]     cnt_q [CH_NUM];
   logic        [ACC_W-1:0]        acc_sum;
   logic                           last;

   logic                           vld_p2_d, vld_p2_q;
   logic        [ACC_W-1:0]        res_p2_d, res_p2_q;
   logic        [CH_W-1:0]         ch_p2_d, ch_p2_q;

   logic        [OUTPUT_WIDTH:0]   sat_res;
   logic signed [OUTPUT_WIDTH-1:0] dout_d, dout_q;
   logic        [CH_W-1:0]         dout_ch_d, dout_ch_q;
   logic                           data_valid_d, data_valid_q;
   logic                           sat_d, sat_q;

   assign din_x = SQ_W'(din);
   assign prod  = din_x * din_x;

   always_comb begin
      // stage 1: square and channel filter
      vld_p1_d = en && ({1'b0, ch} < CH_LIM);
      sq_p1_d  = $unsigned(prod);
      ch_p1_d  = ch;

      // stage 2: per-channel accumulate; the block's last sample clears its slot
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      acc_sum  = acc_q[ch_p1_q] + ACC_W'(sq_p1_q);
      last     = (cnt_q[ch_p1_q] == CNT_LAST);
      vld_p2_d = vld_p1_q && last;
      res_p2_d = acc_sum;
      ch_p2_d  = ch_p1_q;
      if (vld_p1_q) begin
         if (last) begin
            acc_d[ch_p1_q] = '0;
            cnt_d[ch_p1_q] = '0;
         end else begin
            acc_d[ch_p1_q] = acc_sum;
            cnt_d[ch_p1_q] = cnt_q[ch_p1_q] + CNT_ONE;
         end
      end

      // stage 3: scale, saturate, present
      sat_res      = saturate(scale(res_p2_q));
      data_valid_d = vld_p2_q;
      sat_d        = vld_p2_q && sat_res[OUTPUT_WIDTH];
      dout_d       = dout_q;
      dout_ch_d    = dout_ch_q;
      if (vld_p2_q) begin
         dout_d    = $signed(sat_res[OUTPUT_WIDTH-1:0]);
         dout_ch_d = ch_p2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q     <= 1'b0;
         vld_p2_q     <= 1'b0;
         acc_q        <= '{default: '0};
         cnt_q        <= '{default: '0};
         dout_q       <= '0;
         dout_ch_q    <= '0;
         data_valid_q <= 1'b0;
         sat_q        <= 1'b0;
      end else begin
         vld_p1_q     <= vld_p1_d;
         vld_p2_q     <= vld_p2_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_ch_q    <= dout_ch_d;
         data_valid_q <= data_valid_d;
         sat_q        <= sat_d;
      end
   end

   // Payload registers are qualified by the valids, so they carry no reset.
   always_ff @(posedge clk) begin
      sq_p1_q  <= sq_p1_d;
      ch_p1_q  <= ch_p1_d;
      res_p2_q <= res_p2_d;
      ch_p2_q  <= ch_p2_d;
   end

   assign dout       = dout_q;
   assign dout_ch    = dout_ch_q;
   assign data_valid = data_valid_q;
   assign sat        = sat_q;

endmodule

// File: tb/tb_ps_window_mc.sv
// Directed bench for ps_window_mc: a 4-channel/40-bit instance and a 5-channel/32-bit
// instance (saturation and out-of-range channel) driven by the same sample stream.
`timescale 1ns/1ps
module tb_ps_window_mc;
   localparam int DW = 16;
`ifdef PS_MEAN_EN
   localparam int     SH      = 2;
   localparam longint B_SAT_V = 64'd1073741824;
   localparam bit     B_SAT_S = 1'b0;
`else
   localparam int     SH      = 0;
   localparam longint B_SAT_V = 64'd2147483647;
   localparam bit     B_SAT_S = 1'b1;
`endif

   typedef struct {
      longint v;
      int     c;
      bit     s;
      int     cy;
   } pulse_t;

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, en_a = 1'b0;
   logic [1:0] ch_a = '0;
   logic [2:0] ch_b = '0;
   logic signed [DW-1:0] din = '0;
   logic signed [39:0] dout_a;
   logic [1:0] dch_a;
   logic dv_a, sat_a;
   logic signed [31:0] dout_b;
   logic [2:0] dch_b;
   logic dv_b, sat_b;

   int n_cmp = 0, n_bad = 0, cyc = 0, stray = 0;
   pulse_t qa[$], qb[$];

   ps_window_mc #(.DATA_WIDTH(16), .CH_NUM(4), .WIN_LOG2(2), .OUTPUT_WIDTH(40)) u_a (
      .clk(clk), .rst(rst), .en(en_a), .din(din), .ch(ch_a),
      .dout(dout_a), .dout_ch(dch_a), .data_valid(dv_a), .sat(sat_a));

   ps_window_mc #(.DATA_WIDTH(16), .CH_NUM(5), .WIN_LOG2(2), .OUTPUT_WIDTH(32)) u_b (
      .clk(clk), .rst(rst), .en(en), .din(din), .ch(ch_b),
      .dout(dout_b), .dout_ch(dch_b), .data_valid(dv_b), .sat(sat_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dv_a) qa.push_back('{v: longint'(dout_a), c: int'(dch_a), s: sat_a, cy: cyc});
      if (dv_b) qb.push_back('{v: longint'(dout_b), c: int'(dch_b), s: sat_b, cy: cyc});
      if ((sat_a && !dv_a) || (sat_b && !dv_b)) stray++;
   end

   task automatic drive(input logic e, input int c, input int d);
      @(negedge clk);
      en   = e;
      ch_b = c[2:0];
      ch_a = c[1:0];
      en_a = e && (c < 4);
      din  = DW'(d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (dout_a !== '0)  begin n_bad++; $display("FAIL rst_dout_a: got %0d want 0", dout_a); end
      n_cmp++; if (dch_a !== '0)   begin n_bad++; $display("FAIL rst_dch_a: got %0d want 0", dch_a); end
      n_cmp++; if (dv_a !== 1'b0)  begin n_bad++; $display("FAIL rst_dv_a: got %b want 0", dv_a); end
      n_cmp++; if (sat_a !== 1'b0) begin n_bad++; $display("FAIL rst_sat_a: got %b want 0", sat_a); end
      n_cmp++; if (dout_b !== '0)  begin n_bad++; $display("FAIL rst_dout_b: got %0d want 0", dout_b); end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_single();
      int k;
      qa.delete(); qb.delete();
      for (int i = 0; i < 4; i++) drive(1'b1, 0, 3);
      k = cyc;
      idle(6);
      n_cmp++; if (qa.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", qa.size()); end
      if (qa.size() == 1) begin
         n_cmp++; if (qa[0].v != (longint'(36) >> SH)) begin n_bad++; $display("FAIL single_dout: got %0d want %0d", qa[0].v, longint'(36) >> SH); end
         n_cmp++; if (qa[0].c != 0)      begin n_bad++; $display("FAIL single_ch: got %0d want 0", qa[0].c); end
         n_cmp++; if (qa[0].s != 1'b0)   begin n_bad++; $display("FAIL single_sat: got %0d want 0", qa[0].s); end
         n_cmp++; if (qa[0].cy != k + 3) begin n_bad++; $display("FAIL single_latency: got cycle %0d want %0d", qa[0].cy, k + 3); end
      end
   endtask

   task automatic test_interleave();
      int te[13] = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 1};
      int tc[13] = '{0, 1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 1};
      int td[13] = '{1, -2, 0, 1, 1000, -2, 0, 0, 1, -2, 1, 0, -2};
      qa.delete(); qb.delete();
      for (int i = 0; i < 13; i++) drive(te[i][0], tc[i], td[i]);
      idle(6);
      n_cmp++; if (qa.size() != 2) begin n_bad++; $display("FAIL inter_count_a: got %0d want 2", qa.size()); end
      n_cmp++; if (qb.size() != 2) begin n_bad++; $display("FAIL inter_count_b: got %0d want 2", qb.size()); end
      if (qa.size() == 2) begin
         n_cmp++; if (qa[0].c != 0 || qa[0].v != (longint'(4) >> SH))  begin n_bad++; $display("FAIL inter_a0: got ch%0d %0d want ch0 %0d", qa[0].c, qa[0].v, longint'(4) >> SH); end
         n_cmp++; if (qa[1].c != 1 || qa[1].v != (longint'(16) >> SH)) begin n_bad++; $display("FAIL inter_a1: got ch%0d %0d want ch1 %0d", qa[1].c, qa[1].v, longint'(16) >> SH); end
      end
      if (qb.size() == 2) begin
         n_cmp++; if (qb[0].c != 0 || qb[0].v != (longint'(4) >> SH))  begin n_bad++; $display("FAIL inter_b0: got ch%0d %0d want ch0 %0d", qb[0].c, qb[0].v, longint'(4) >> SH); end
         n_cmp++; if (qb[1].c != 1 || qb[1].v != (longint'(16) >> SH)) begin n_bad++; $display("FAIL inter_b1: got ch%0d %0d want ch1 %0d", qb[1].c, qb[1].v, longint'(16) >> SH); end
      end
   endtask

   task automatic test_saturate();
      qa.delete(); qb.delete();
      for (int i = 0; i < 4; i++) drive(1'b1, 2, -32768);
      idle(6);
      n_cmp++; if (qa.size() != 1 || qb.size() != 1) begin n_bad++; $display("FAIL sat_count: got %0d/%0d want 1/1", qa.size(), qb.size()); end
      if (qa.size() == 1) begin
         n_cmp++; if (qa[0].v != (64'd4294967296 >> SH)) begin n_bad++; $display("FAIL sat_a_dout: got %0d want %0d", qa[0].v, 64'd4294967296 >> SH); end
         n_cmp++; if (qa[0].s != 1'b0 || qa[0].c != 2)   begin n_bad++; $display("FAIL sat_a_flag: got sat%0d ch%0d want sat0 ch2", qa[0].s, qa[0].c); end
      end
      if (qb.size() == 1) begin
         n_cmp++; if (qb[0].v != B_SAT_V) begin n_bad++; $display("FAIL sat_b_dout: got %0d want %0d", qb[0].v, B_SAT_V); end
         n_cmp++; if (qb[0].s != B_SAT_S) begin n_bad++; $display("FAIL sat_b_flag: got %0d want %0d", qb[0].s, B_SAT_S); end
      end
   endtask

   task automatic test_back_to_back();
      qa.delete(); qb.delete();
      for (int i = 0; i < 8; i++) drive(1'b1, 3, 2);
      idle(6);
      n_cmp++; if (qa.size() != 2 || qb.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d/%0d want 2/2", qa.size(), qb.size()); end
      if (qa.size() == 2) begin
         n_cmp++; if (qa[0].v != (longint'(16) >> SH) || qa[1].v != (longint'(16) >> SH)) begin n_bad++; $display("FAIL b2b_dout: got %0d,%0d want %0d", qa[0].v, qa[1].v, longint'(16) >> SH); end
         n_cmp++; if (qa[1].cy - qa[0].cy != 4) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 4", qa[1].cy - qa[0].cy); end
         n_cmp++; if (qa[0].c != 3 || qa[1].c != 3) begin n_bad++; $display("FAIL b2b_ch: got %0d,%0d want 3", qa[0].c, qa[1].c); end
      end
      if (qb.size() == 2) begin
         n_cmp++; if (qb[0].v != (longint'(16) >> SH) || qb[1].v != (longint'(16) >> SH)) begin n_bad++; $display("FAIL b2b_dout_b: got %0d,%0d want %0d", qb[0].v, qb[1].v, longint'(16) >> SH); end
      end
      n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL sat_without_valid: got %0d cycles want 0", stray); end
   endtask

   task automatic test_reset_mid_window();
      qa.delete(); qb.delete();
      drive(1'b1, 0, 100);
      drive(1'b1, 0, 100);
      @(negedge clk);
      en = 1'b0; en_a = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++; if (dout_a !== '0 || dch_a !== '0 || dv_a !== 1'b0 || sat_a !== 1'b0) begin n_bad++; $display("FAIL midrst_outputs: got dout=%0d ch=%0d dv=%b sat=%b want all 0", dout_a, dch_a, dv_a, sat_a); end
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      for (int i = 0; i < 4; i++) drive(1'b1, 0, 1);
      idle(6);
      n_cmp++; if (qa.size() != 1) begin n_bad++; $display("FAIL midrst_count: got %0d want 1", qa.size()); end
      if (qa.size() == 1) begin
         n_cmp++; if (qa[0].v != (longint'(4) >> SH)) begin n_bad++; $display("FAIL midrst_dout: got %0d want %0d", qa[0].v, longint'(4) >> SH); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_interleave();
      test_saturate();
      test_back_to_back();
      test_reset_mid_window();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps_window_mc.md
Name: ps_window_mc

Overview:
Multi-channel windowed signal-power estimator for the iEEG seizure-detection datapath.
- Accepts time-multiplexed signed samples tagged with a channel index.
- Per channel, accumulates the sum of squares over non-overlapping blocks of 2^WIN_LOG2 samples.
- Emits one power value per completed block, tagged with its channel.
- Generalises the single-channel power-sum stage: configurable channel count and window, saturating output, optional mean mode.

Parameters:
DATA_WIDTH, 16, signed input sample width
CH_NUM, 4, number of interleaved channels (>=1)
WIN_LOG2, 8, log2 of window length in samples per channel (>=1)
OUTPUT_WIDTH, 40, signed output width; exact (no saturation) when OUTPUT_WIDTH >= 2*DATA_WIDTH+WIN_LOG2+1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  sample valid; din/ch sampled on clk rising edge when high
din  input  DATA_WIDTH  signed sample
ch  input  max(1,$clog2(CH_NUM))  channel index of din
dout  output  OUTPUT_WIDTH  signed block power (always >= 0)
dout_ch  output  max(1,$clog2(CH_NUM))  channel of dout
data_valid  output  1  one-cycle pulse, dout/dout_ch valid
sat  output  1  high with data_valid when dout was saturated

Behaviour:
- Reset (async assert, sync release): all accumulators, per-channel counters and pipeline valids cleared. dout=0, dout_ch=0, data_valid=0, sat=0.
- Stage 1 (edge where en=1 and ch<CH_NUM): register sq = din*din as 2*DATA_WIDTH-bit unsigned, plus ch and a valid bit.
  - -2^(DATA_WIDTH-1) squared = 2^(2*DATA_WIDTH-2); this must fit.
- Stage 2: acc[ch] += sq; cnt[ch]++.
  - Accumulator width = 2*DATA_WIDTH+WIN_LOG2 bits, never wraps.
- When cnt[ch] reaches 2^WIN_LOG2-1 before the add (last sample of the block):
  - dout <= result, dout_ch <= ch, data_valid <= 1.
  - acc[ch] <= 0, cnt[ch] <= 0 in the same edge.
- Latency: data_valid rises on the 2nd rising edge after the edge that captured the final sample. Fully pipelined, 1 sample/cycle.
- en=0: bubble; no state change; data_valid pulses only for completed blocks.
- ch >= CH_NUM with en=1: sample dropped, no state change, no flag.
- Back-to-back samples on the same channel (including a block completing and the next block's first sample on the following cycle): no sample lost or double counted. Stage 2 read-modify-write of acc[ch] uses the registered array value, so no forwarding hazard.
- Saturation: if result > 2^(OUTPUT_WIDTH-1)-1, dout = 2^(OUTPUT_WIDTH-1)-1 and sat=1 for that pulse; otherwise sat=0. The internal accumulator is unaffected.
- data_valid and sat are low in every cycle without a completed block. dout/dout_ch hold their last value.
- Reset mid-window discards all partial blocks and in-flight samples; no pulse is generated from pre-reset data.

Optional Feature:
Macro PS_MEAN_EN.
- Defined: output value is the block mean power, result >> WIN_LOG2 (truncating). The shift is applied before the saturation check.
- Undefined: raw sum of squares as above.
- Latency, handshake and ports are identical in both builds.

Test Plan (CH_NUM=4, WIN_LOG2=2, DATA_WIDTH=16, OUTPUT_WIDTH=40 unless noted):
1. ch=0, din=3, four consecutive en cycles -> single data_valid pulse 2 cycles after the 4th sample, dout=36, dout_ch=0, sat=0. With PS_MEAN_EN: dout=9.
2. Alternate ch0 din=1 / ch1 din=-2 for 8 cycles, with en gaps inserted -> ch0 pulse dout=4, ch1 pulse dout=16, in completion order. A sample on ch=5 mid-stream is ignored and both results are unchanged.
3. ch=2, din=-32768 ×4 -> dout=4294967296, sat=0. Same stimulus with OUTPUT_WIDTH=32 -> dout=2147483647, sat=1.
4. ch=3 back-to-back: 8 samples of din=2 -> two pulses, dout=16 each, exactly 4 cycles apart.
5. ch=0: 2 samples of din=100, assert rst for 1 cycle, then 4 samples of din=1 -> no pulse from pre-reset data; one pulse with dout=4. All outputs are 0 during reset.
